tlul_sram_device_adapter: RTL

Device-side TL-UL endpoint that terminates traffic from `tlul_host_adapter` (or a crossbar port fed by it) and drives a simple SRAM-style req/gnt/rvalid memory port. It is the consumer of the A channel that the host adapter produces, and the producer of the D channel that the host adapter returns to its agent. It supports up to `Outstanding` in-flight requests, returns responses in order, and optionally flags malformed requests with `d_error`.

---
 rtl/tlul_sram_device_adapter.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/tlul_sram_device_adapter.sv
// TL-UL device adapter: terminates TL-UL A/D traffic and drives an SRAM-style
// req/gnt/rvalid port. Up to Outstanding requests in flight, in-order replies.
// Optional request checking is enabled by defining TLUL_SRAM_ERR_CHECK_EN;
// without it every request is forwarded and d_error reflects only rerr_i.

package tlul_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_DBW = 4;
  localparam int TL_SZW = 2;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic                a_valid;
    tl_a_op_e            a_opcode;
    logic [TL_SZW-1:0]   a_size;
    logic [TL_AIW-1:0]   a_source;
    logic [TL_AW-1:0]    a_address;
    logic [TL_DBW-1:0]   a_mask;
    logic [TL_DW-1:0]    a_data;
    logic                d_ready;
  } tlul_h2d_t;

  typedef struct packed {
    logic                d_valid;
    tl_d_op_e            d_opcode;
    logic [2:0]          d_param;
    logic [TL_SZW-1:0]   d_size;
    logic [TL_AIW-1:0]   d_source;
    logic [TL_DIW-1:0]   d_sink;
    logic [TL_DW-1:0]    d_data;
    logic                d_error;
    logic                a_ready;
  } tlul_d2h_t;
endpackage

// Protocol checker: a memory response must always match a granted request.
module tlul_sram_device_adapter_chk #(
  parameter int CW = 2
) (
  input logic          clk_i,
  input logic          rst_i,
  input logic          rvalid_i,
  input logic [CW-1:0] mem_pend
);
  rvalid_has_request: assert property (@(posedge clk_i) disable iff (rst_i)
    rvalid_i |-> (mem_pend != {CW{1'b0}}));
endmodule

module tlul_sram_device_adapter
  import tlul_pkg::*;
#(
  parameter int SramAw      = 12,
  parameter int Outstanding = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  tlul_h2d_t         tl_d_c_a,
  output tlul_d2h_t         tl_d_c_d,
  output logic              req_o,
  input  logic              gnt_i,
  output logic              we_o,
  output logic [SramAw-1:0] addr_o,
  output logic [TL_DW-1:0]  wdata_o,
  output logic [TL_DBW-1:0] be_o,
  input  logic              rvalid_i,
  input  logic [TL_DW-1:0]  rdata_i,
  input  logic              rerr_i
);
  localparam int PW = (Outstanding > 1) ? $clog2(Outstanding) : 1;
  localparam int CW = $clog2(Outstanding + 1);
  localparam logic [CW-1:0] DEPTH = CW'(Outstanding);
  localparam logic [PW-1:0] LAST  = PW'(Outstanding - 1);

  typedef struct packed {
    tl_a_op_e          opcode;
    logic [TL_AIW-1:0] source;
    logic [TL_SZW-1:0] size;
    logic              bad;
  } info_t;

  typedef struct packed {
    logic [TL_DW-1:0] data;
    logic             err;
  } rsp_t;

  // Pointers wrap modulo Outstanding so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? {PW{1'b0}} : p + PW'(1'b1);
  endfunction

  info_t         info_mem [Outstanding];
  info_t         info_head;
  info_t         info_push;
  logic [PW-1:0] info_wptr, info_rptr;
  logic [CW-1:0] info_cnt;

  rsp_t          rsp_mem [Outstanding];
  rsp_t          rsp_head;
  logic [PW-1:0] rsp_wptr, rsp_rptr;
  logic [CW-1:0] rsp_cnt;

  logic [CW-1:0] mem_pend;
  logic          space, bad, a_ready, accept, mem_grant;
  logic          rsp_push, rsp_pop, head_ready, d_valid, d_fire;
  logic          unused_addr;

`ifdef TLUL_SRAM_ERR_CHECK_EN
  // Flags requests the memory port cannot legally carry.
  function automatic logic req_bad(input tlul_h2d_t a);
    logic            op_bad, size_bad, align_bad, mask_bad, addr_bad;
    logic [TL_DBW-1:0] full_mask;
    case (a.a_opcode)
      Get, PutFullData, PutPartialData: op_bad = 1'b0;
      default:                          op_bad = 1'b1;
    endcase
    case (a.a_size)
      2'd0: begin align_bad = 1'b0;              full_mask = 4'b0001 << a.a_address[1:0]; end
      2'd1: begin align_bad = a.a_address[0];    full_mask = 4'b0011 << a.a_address[1:0]; end
      2'd2: begin align_bad = |a.a_address[1:0]; full_mask = 4'b1111; end
      default: begin align_bad = 1'b1;           full_mask = 4'b0000; end
    endcase
    size_bad = (a.a_size > 2'd2);
    mask_bad = (a.a_opcode == PutFullData) && (a.a_mask != full_mask);
    addr_bad = |(a.a_address >> (SramAw + 2));
    return op_bad | size_bad | align_bad | mask_bad | addr_bad;
  endfunction

  assign bad = req_bad(tl_d_c_a);
`else
  assign bad = 1'b0;
`endif

  // Only the word-address slice reaches memory in the unchecked build.
  assign unused_addr = ^tl_d_c_a.a_address;

  assign space     = (info_cnt < DEPTH);
  assign req_o     = tl_d_c_a.a_valid & space & ~bad & ~rst_i;
  assign a_ready   = space & (bad | gnt_i) & ~rst_i;
  assign accept    = tl_d_c_a.a_valid & a_ready;
  assign mem_grant = req_o & gnt_i;
  assign we_o      = (tl_d_c_a.a_opcode != Get);
  assign addr_o    = tl_d_c_a.a_address[SramAw+1:2];
  assign wdata_o   = tl_d_c_a.a_data;
  assign be_o      = tl_d_c_a.a_mask;

  assign info_push = '{opcode: tl_d_c_a.a_opcode, source: tl_d_c_a.a_source,
                       size: tl_d_c_a.a_size, bad: bad};
  assign info_head = info_mem[info_rptr];
  assign rsp_head  = rsp_mem[rsp_rptr];

  // Late responses with nothing outstanding are dropped rather than queued.
  assign rsp_push   = rvalid_i & (mem_pend != {CW{1'b0}});
  assign head_ready = info_head.bad | (rsp_cnt != {CW{1'b0}});
  assign d_valid    = (info_cnt != {CW{1'b0}}) & head_ready;
  assign d_fire     = d_valid & tl_d_c_a.d_ready;
  assign rsp_pop    = d_fire & ~info_head.bad;

  // Request-info FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      info_wptr <= {PW{1'b0}};
      info_rptr <= {PW{1'b0}};
      info_cnt  <= {CW{1'b0}};
    end else begin
      if (accept) info_wptr <= ptr_inc(info_wptr);
      if (d_fire) info_rptr <= ptr_inc(info_rptr);
      case ({accept, d_fire})
        2'b10:   info_cnt <= info_cnt + CW'(1'b1);
        2'b01:   info_cnt <= info_cnt - CW'(1'b1);
        default: info_cnt <= info_cnt;
      endcase
    end
  end

  // Request-info FIFO storage.
  always_ff @(posedge clk_i) begin
    if (accept) info_mem[info_wptr] <= info_push;
  end

  // Response-data FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_wptr <= {PW{1'b0}};
      rsp_rptr <= {PW{1'b0}};
      rsp_cnt  <= {CW{1'b0}};
    end else begin
      if (rsp_push) rsp_wptr <= ptr_inc(rsp_wptr);
      if (rsp_pop)  rsp_rptr <= ptr_inc(rsp_rptr);
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_cnt <= rsp_cnt + CW'(1'b1);
        2'b01:   rsp_cnt <= rsp_cnt - CW'(1'b1);
        default: rsp_cnt <= rsp_cnt;
      endcase
    end
  end

  // Response-data FIFO storage.
  always_ff @(posedge clk_i) begin
    if (rsp_push) rsp_mem[rsp_wptr] <= '{data: rdata_i, err: rerr_i};
  end

  // Count of granted memory requests still awaiting rvalid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_pend <= {CW{1'b0}};
    end else begin
      case ({mem_grant, rsp_push})
        2'b10:   mem_pend <= mem_pend + CW'(1'b1);
        2'b01:   mem_pend <= mem_pend - CW'(1'b1);
        default: mem_pend <= mem_pend;
      endcase
    end
  end

  // D channel built from the FIFO heads.
  always_comb begin
    tl_d_c_d          = '0;
    tl_d_c_d.a_ready  = a_ready;
    tl_d_c_d.d_valid  = d_valid;
    tl_d_c_d.d_source = info_head.source;
    tl_d_c_d.d_size   = info_head.size;
    if (info_head.opcode == Get) begin
      tl_d_c_d.d_opcode = AccessAckData;
    end else begin
      tl_d_c_d.d_opcode = AccessAck;
    end
    if (info_head.bad) begin
      tl_d_c_d.d_error = 1'b1;
    end else begin
      tl_d_c_d.d_error = rsp_head.err;
      if (info_head.opcode == Get) begin
        tl_d_c_d.d_data = rsp_head.data;
      end else begin
        tl_d_c_d.d_data = {TL_DW{1'b0}};
      end
    end
  end

  tlul_sram_device_adapter_chk #(.CW(CW)) u_chk (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rvalid_i (rvalid_i),
    .mem_pend (mem_pend)
  );
endmodule
